// File: rtl/encoder4.sv
// rtl/encoder4.sv - serial 4-bit pattern transmitter with repeated bursts and inter-frame gaps
module encoder4 #(
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prgm_en,
    input  logic       prgm,
    input  logic       send,
    input  logic [3:0] count,
    output logic       sig,
    output logic       sig_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] code,
    output logic       code_ok
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t     state;
    logic [3:0] tx;
    logic [3:0] reps;
    logic [3:0] gap_cnt;
    logic [1:0] bit_idx;
    logic [2:0] pcnt;

    // bit_idx always names the tx bit currently driven on sig, so the first
    // bit is launched on the same edge that accepts send.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx        <= 4'd0;
            reps      <= 4'd0;
            gap_cnt   <= 4'd0;
            bit_idx   <= 2'd0;
            pcnt      <= 3'd0;
            code      <= 4'd0;
            code_ok   <= 1'b0;
            sig       <= 1'b0;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (send && code_ok) begin
                        tx        <= code;
                        reps      <= (count == 4'd0) ? 4'd1 : count;
                        bit_idx   <= 2'd3;
                        busy      <= 1'b1;
                        sig       <= code[3];
                        sig_valid <= 1'b1;
                        state     <= S_SHIFT;
                    end else if (prgm_en && !send) begin
                        code <= {code[2:0], prgm};
                        if (pcnt != 3'd7) begin
                            pcnt <= pcnt + 3'd1;
                        end
                        if (pcnt >= 3'd3) begin
                            code_ok <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bit_idx != 2'd0) begin
                        bit_idx <= bit_idx - 2'd1;
                        sig     <= tx[bit_idx - 2'd1];
                    end else if (reps > 4'd1) begin
                        reps <= reps - 4'd1;
                        if (GAP > 0) begin
                            state     <= S_GAP;
                            gap_cnt   <= GAP_LAST;
                            sig       <= 1'b0;
                            sig_valid <= 1'b0;
                        end else begin
                            bit_idx <= 2'd3;
                            sig     <= tx[3];
                        end
                    end else begin
                        state     <= S_IDLE;
                        sig       <= 1'b0;
                        sig_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state     <= S_SHIFT;
                        bit_idx   <= 2'd3;
                        sig       <= tx[3];
                        sig_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/encoder4.md
# encoder4

Serial pattern transmitter that pairs with the `decoder4` block. A 4-bit code is programmed serially, then transmitted MSB-first on a single-bit `sig` line when `send` is pulsed. Each transmission is a burst of `count` repetitions of the code, with `GAP` idle cycles between repetitions. The block drives the `sig` input of a downstream `decoder4`, and benches use it as the stimulus source for that decoder.

## Interface
- `GAP`, default 2: idle cycles inserted between repetitions of a burst (legal range 0–15).
- `clk`  in  1  system clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prgm_en`  in  1  programming enable; while high in IDLE, one code bit is shifted in per cycle.
- `prgm`  in  1  serial program bit, MSB first.
- `send`  in  1  single-cycle request to start a burst.
- `count`  in  4  repetitions per burst; sampled with `send`; 0 is treated as 1.
- `sig`  out  1  serial code output (the decoder's `sig`).
- `sig_valid`  out  1  high while `sig` carries a code bit.
- `busy`  out  1  high from burst acceptance through the last bit.
- `done`  out  1  one-cycle pulse after the final bit of a burst.
- `code`  out  4  current programmed code (readback).
- `code_ok`  out  1  high once at least 4 bits have been programmed since reset.

## Operation
- Reset values: `sig`=0, `sig_valid`=0, `busy`=0, `done`=0, `code`=4'b0000, `code_ok`=0, state=IDLE, all counters 0.
- Programming happens in IDLE only.
  - Each cycle with `prgm_en`=1 and `send`=0: `code <= {code[2:0], prgm}`.
  - A saturating 3-bit program counter increments on each programmed bit. `code_ok` sets when the counter reaches 4.
  - Programming more than 4 bits keeps the last 4 bits.
  - `prgm_en` is ignored outside IDLE.
- The state machine has three states: IDLE, SHIFT, GAP.
- IDLE → SHIFT happens on `send`=1 with `code_ok`=1. At that edge:
  - `tx <= code` (snapshot).
  - `reps <= (count==0) ? 1 : count`.
  - `bit_idx <= 3`.
  - `busy <= 1`.
- `send` is ignored when `code_ok`=0 or when the block is not in IDLE. No queuing.
- If `send` and `prgm_en` are both high in IDLE, `send` wins and no bit is shifted that cycle.
- SHIFT: `sig = tx[bit_idx]`, `sig_valid`=1; `bit_idx` decrements each cycle. After `bit_idx`==0:
  - `reps`>1 and `GAP`>0: decrement `reps`, go to GAP.
  - `reps`>1 and `GAP`==0: decrement `reps`, reload `bit_idx`=3, stay in SHIFT (back-to-back).
  - `reps`==1: go to IDLE, `busy` goes to 0, `done` goes to 1 for one cycle.
- GAP: `sig`=0, `sig_valid`=0, `busy`=1 for exactly `GAP` cycles, then go to SHIFT with `bit_idx`=3.
- The `tx` snapshot is held for the whole burst. Reprogramming cannot occur mid-burst because programming is IDLE-only.
- Reset mid-burst: at the next edge the block returns to reset values. `code` and `code_ok` are cleared, so the code must be reprogrammed before the next burst.

## Timing
- All outputs are registered.
- `send` sampled at edge k puts the first bit (`tx[3]`) on `sig`, with `sig_valid`=1 and `busy`=1, after edge k.
- Bits follow on the next edges: `tx[2]` after k+1, `tx[1]` after k+2, `tx[0]` after k+3.
- Burst length in cycles is `4*reps + (reps-1)*GAP`. `done` is high for the single cycle right after the last bit; `busy` is 0 in that same cycle.
- A new `send` is accepted in the `done` cycle, since the block is in IDLE by then.
- `code_ok` rises in the cycle after the 4th programmed bit's edge. A `send` in that cycle is accepted.
- `sig`=0 whenever `sig_valid`=0.

## Test plan
- **Reset/program:** assert `rst` for 2 cycles → all outputs 0. Then `prgm_en`=1 with `prgm`=1,0,1,1 on 4 cycles → `code`=4'b1011, `code_ok`=1.
- **Single burst:** `count`=1, pulse `send` → `sig`=1,0,1,1 with `sig_valid` high for exactly 4 cycles. `done` pulses once in the 5th cycle; `busy` is low from then on.
- **Repeated burst:** `GAP`=2, `count`=3 → 3 frames of 1011 separated by 2 cycles of `sig_valid`=0. `busy` stays high for 16 cycles, followed by a single `done`.
- **Edge cases:**
  - `count`=0 → exactly one frame.
  - `send` before `code_ok` → no `sig_valid`, `busy` stays 0.
  - `send` during a burst → ignored; the frame count is unchanged.
  - `send` and `prgm_en` in the same cycle → burst starts, `code` is unchanged.
- **Reset mid-burst:** assert `rst` during the 2nd bit → the next cycle has `sig`=`sig_valid`=`busy`=0 and `code_ok`=0, with no `done` pulse.
- **Loopback with decoder4:** program `decoder4` and `encoder4` with the same code, then send → the decoder `out` asserts once per frame. With mismatched codes (1011 vs 1001), `out` never asserts.
